// File: rtl/m_control.sv
// M-extension sequencer: drives the multiply/divide datapath mux selects
// and the writeback result-shaping flags for one operation at a time.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH
`define MUX_A_LENGTH      2
`define MUX_A_KEEP        2'd0
`define MUX_A_RS1_S       2'd1
`define MUX_A_RS1_U       2'd2
`define MUX_B_LENGTH      2
`define MUX_B_KEEP        2'd0
`define MUX_B_RS2_S       2'd1
`define MUX_B_RS2_U       2'd2
`define MUX_R_LENGTH      3
`define MUX_R_KEEP        3'd0
`define MUX_R_A           3'd1
`define MUX_R_A_NEG       3'd2
`define MUX_R_SUB_KEEP    3'd3
`define MUX_R_MULT_LOWER  3'd4
`define MUX_R_ZERO        3'd5
`define MUX_D_LENGTH      2
`define MUX_D_KEEP        2'd0
`define MUX_D_B           2'd1
`define MUX_D_B_NEG       2'd2
`define MUX_D_SHR         2'd3
`define MUX_Z_LENGTH      2
`define MUX_Z_KEEP        2'd0
`define MUX_Z_ZERO        2'd1
`define MUX_Z_SHL_ADD     2'd2
`define MUX_Z_MULT_UPPER  2'd3
`endif

module m_control #(
   parameter int DIV_ITERS   = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic                     rs1_sign,
   input  logic                     rs2_sign,
   input  logic                     rs2_zero,
   input  logic                     rs1_min,
   input  logic                     rs2_ones,
   output logic [`MUX_A_LENGTH-1:0] mux_A,
   output logic [`MUX_B_LENGTH-1:0] mux_B,
   output logic [`MUX_R_LENGTH-1:0] mux_R,
   output logic [`MUX_D_LENGTH-1:0] mux_D,
   output logic [`MUX_Z_LENGTH-1:0] mux_Z,
   output logic                     res_sel,
   output logic                     res_neg,
   output logic [1:0]               res_force,
   output logic                     busy,
   output logic                     done
);

   localparam int CNT_MAX = (DIV_ITERS > MUL_LATENCY) ? DIV_ITERS : MUL_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITERS - 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIV_ITER,
      S_MUL_WAIT,
      S_SPECIAL,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            s1_q, s1_d;
   logic            s2_q, s2_d;
   logic            z_q, z_d;
   logic            mn_q, mn_d;
   logic            on_q, on_d;

   logic            special_in;
   logic            special_q;
   logic [`MUX_A_LENGTH-1:0] a_sel;
   logic [`MUX_B_LENGTH-1:0] b_sel;

   // Divide-by-zero or signed overflow bypass the iterative datapath.
   assign special_in = op[2] & (rs2_zero | (~op[0] & rs1_min & rs2_ones));
   assign special_q  = op_q[2] & (z_q | (~op_q[0] & mn_q & on_q));

   // Operand extension: only MULHU treats rs1 as unsigned, MULHSU/MULHU rs2.
   assign a_sel = (op_q == 3'd3) ? `MUX_A_RS1_U : `MUX_A_RS1_S;
   assign b_sel = op_q[1] ? `MUX_B_RS2_U : `MUX_B_RS2_S;

   // Result shaping derives from latched operands, so it is stable until the next accept.
   always_comb begin
      res_sel   = (op_q == 3'd4) | (op_q == 3'd5) |
                  (op_q == 3'd1) | (op_q == 3'd2) | (op_q == 3'd3);
      res_neg   = 1'b0;
      res_force = 2'd0;
      if (op_q == 3'd4) res_neg = s1_q ^ s2_q;
      if (op_q == 3'd6) res_neg = s1_q;
      if (special_q) begin
         if (z_q) res_force = op_q[1] ? 2'd2 : 2'd1;
         else     res_force = op_q[1] ? 2'd2 : 2'd3;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

   // Next-state, counter and mux-select decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      z_d     = z_q;
      mn_d    = mn_q;
      on_d    = on_q;
      mux_A   = `MUX_A_KEEP;
      mux_B   = `MUX_B_KEEP;
      mux_R   = `MUX_R_KEEP;
      mux_D   = `MUX_D_KEEP;
      mux_Z   = `MUX_Z_KEEP;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               s1_d    = rs1_sign;
               s2_d    = rs2_sign;
               z_d     = rs2_zero;
               mn_d    = rs1_min;
               on_d    = rs2_ones;
               state_d = special_in ? S_SPECIAL : S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d = '0;
            if (op_q[2]) begin
               mux_R   = (~op_q[0] & s1_q) ? `MUX_R_A_NEG : `MUX_R_A;
               mux_D   = (~op_q[0] & s2_q) ? `MUX_D_B_NEG : `MUX_D_B;
               mux_Z   = `MUX_Z_ZERO;
               state_d = S_DIV_ITER;
            end else begin
               mux_A   = a_sel;
               mux_B   = b_sel;
               state_d = S_MUL_WAIT;
            end
         end
         S_DIV_ITER: begin
            mux_R = `MUX_R_SUB_KEEP;
            mux_D = `MUX_D_SHR;
            mux_Z = `MUX_Z_SHL_ADD;
            if (cnt_q == DIV_LAST) state_d = S_DONE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         S_MUL_WAIT: begin
            mux_A = a_sel;
            mux_B = b_sel;
            mux_R = `MUX_R_MULT_LOWER;
            mux_Z = `MUX_Z_MULT_UPPER;
            if (cnt_q == MUL_LAST) state_d = S_DONE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         S_SPECIAL: state_d = S_DONE;
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and operand-flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 3'd0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         z_q     <= 1'b0;
         mn_q    <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         z_q     <= z_d;
         mn_q    <= mn_d;
         on_q    <= on_d;
      end
   end

endmodule

// File: doc/m_control.md
M_CONTROL -- requirements
Module: m_control

Interface
REQ-001 SHALL have parameter DIV_ITERS, default 32: number of restoring-division iterations.
REQ-002 SHALL have parameter MUL_LATENCY, default 2: cycles from multiplier operand select until product is valid.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a new M-extension operation; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3: funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 SHALL have ports rs1_sign and rs2_sign, input, 1 each: bit 31 of rs1 and rs2.
REQ-008 SHALL have port rs2_zero, input, 1: rs2 == 0.
REQ-009 SHALL have port rs1_min, input, 1: rs1 == 32'h80000000.
REQ-010 SHALL have port rs2_ones, input, 1: rs2 == 32'hFFFFFFFF.
REQ-011 SHALL have ports mux_A, mux_B, mux_R, mux_D and mux_Z, output, with widths `MUX_A_LENGTH, `MUX_B_LENGTH, `MUX_R_LENGTH, `MUX_D_LENGTH and `MUX_Z_LENGTH: register-bank selects using the m_definitions.svh codes.
REQ-012 SHALL have port res_sel, output, 1: 0 selects R, 1 selects Z as the result.
REQ-013 SHALL have port res_neg, output, 1: the writeback stage two's-complements the selected result.
REQ-014 SHALL have port res_force, output, 2: 0 none, 1 all-ones, 2 pass rs1, 3 32'h80000000; takes precedence over res_neg.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: single-cycle pulse; result valid in the same cycle.

Function
REQ-017 SHALL implement states IDLE, LOAD, DIV_ITER, MUL_WAIT, SPECIAL and DONE in a single registered state machine with an iteration counter.
REQ-018 In IDLE with start=1, SHALL latch op, rs1_sign, rs2_sign, rs2_zero, rs1_min and rs2_ones, then go to LOAD, or to SPECIAL if op is a divide/remainder with (rs2_zero) or (signed op and rs1_min and rs2_ones).
REQ-019 In LOAD for divide ops, SHALL drive mux_R to MUX_R_A_NEG when signed and rs1_sign=1 (else MUX_R_A), mux_D to MUX_D_B_NEG when signed and rs2_sign=1 (else MUX_D_B), and mux_Z to MUX_Z_ZERO; SHALL clear the counter; next state DIV_ITER.
REQ-020 In DIV_ITER, SHALL drive mux_R to MUX_R_SUB_KEEP, mux_D to MUX_D_SHR and mux_Z to MUX_Z_SHL_ADD for exactly DIV_ITERS cycles, then go to DONE.
REQ-021 In LOAD for multiply ops, SHALL select signed extension of rs1 for MUL/MULH/MULHSU (unsigned for MULHU) and of rs2 for MUL/MULH (unsigned for MULHSU/MULHU); next state MUL_WAIT.
REQ-022 In MUL_WAIT, SHALL hold the mux_A/mux_B selects and drive mux_R to MUX_R_MULT_LOWER and mux_Z to MUX_Z_MULT_UPPER for MUL_LATENCY cycles, then go to DONE.
REQ-023 SHALL drive all selects to their KEEP codes in IDLE, SPECIAL and DONE, and in any state not listed above.
REQ-024 In DONE, SHALL assert done for one cycle and return to IDLE.
REQ-025 SHALL set res_sel=1 for DIV, DIVU, MULH, MULHSU and MULHU; res_sel=0 for MUL, REM and REMU.
REQ-026 SHALL set res_neg = rs1_sign^rs2_sign for DIV, rs1_sign for REM, and 0 otherwise.
REQ-027 For SPECIAL, SHALL go to DONE next cycle with: divide by zero giving DIV/DIVU res_force=1 and REM/REMU res_force=2; overflow giving DIV res_force=3 and REM res_force=0 with R cleared via MUX_R_ZERO... SHALL instead use res_force=2 with rs1 masked to 0 by the writeback stage on overflow REM.
REQ-028 SHALL hold res_sel, res_neg and res_force stable from LOAD/SPECIAL through DONE.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL accept start in the cycle immediately after DONE.
REQ-031 Latency from the start edge to the done cycle SHALL be DIV_ITERS+2 for divide (34), MUL_LATENCY+2 for multiply (4), and 2 for SPECIAL.

Reset
REQ-032 On reset=1 at a rising edge, SHALL enter IDLE with busy=0, done=0, all selects KEEP, res_sel=0, res_neg=0, res_force=0 and counter=0, including mid-operation.
REQ-033 If start and reset are both high, reset SHALL win and no operation SHALL begin.

Verification
REQ-034 DIVU with rs2 nonzero: start at cycle 0 -> LOAD at 1, 32 cycles of SUB_KEEP/SHR/SHL_ADD, done at 34, res_sel=1, res_neg=0.
REQ-035 DIV with rs1 = -7890 and rs2 = 4567 -> mux_R=MUX_R_A_NEG and mux_D=MUX_D_B in LOAD, res_neg=1, done at 34.
REQ-036 MULHSU -> signed rs1 and unsigned rs2 selects, MULT_LOWER/MULT_UPPER for 2 cycles, done at 4, res_sel=1.
REQ-037 DIV with rs2_zero=1 -> done at 2, res_force=1; REM with rs2_zero=1 -> res_force=2.
REQ-038 reset pulsed at cycle 10 of DIV_ITER -> IDLE next edge, busy=0, no done; a new start is then accepted normally.
REQ-039 start held high through a whole operation -> exactly one done per accepted start, and a back-to-back start is accepted the cycle after DONE.
